agc_word_decoder: RTL
=====================

AGC_WORD_DECODER -- requirements
Module: agc_word_decoder

Interface
REQ-001 The block SHALL have no parameters; word width is fixed at 15 bits (AGC one's-complement format: bit 14 = sign, bits 13:0 = data).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-003 Port list (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept an operand pair
- in_word  in  15  one's-complement word to decode
- in_ref  in  15  one's-complement reference for compare
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sign  out  1  decoded sign (0 for either zero)
- out_mag  out  14  decoded magnitude
- out_twos  out  15  two's-complement equivalent of in_word
- out_negzero  out  1  in_word was negative zero (15'h7FFF)
- out_gt  out  1  in_word > in_ref, signed one's-complement
- busy  out  1  compare in progress

Function
REQ-004 States SHALL be IDLE, CMP, DONE; in_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in CMP.
REQ-005 A transfer SHALL occur on a rising edge with in_valid && in_ready; both operands are latched and the state moves IDLE -> CMP.
REQ-006 Magnitude of a word SHALL be bits 13:0 if bit 14 = 0, else ~bits 13:0; negative zero is magnitude 0 with effective sign 0.
REQ-007 CMP SHALL compare the magnitudes serially, one bit per cycle, bit 13 down to bit 0, latching the first differing bit as mag_gt or mag_lt.
REQ-008 Without the macro of REQ-016, CMP SHALL last exactly 14 cycles; out_valid SHALL rise 14 edges after the accepting edge.
REQ-009 out_gt SHALL be: 0 if both operands are zero (either sign); 1 if effective signs are (+,-); 0 if (-,+); mag_gt if both positive; mag_lt if both negative.
REQ-010 out_twos SHALL be {1'b0, mag} for positive or either zero, and the 15-bit two's negation of {1'b0, mag} for negative nonzero.
REQ-011 On leaving CMP the state SHALL be DONE with out_valid = 1; all outputs SHALL hold stable while out_valid && !out_ready.
REQ-012 DONE SHALL move to IDLE on the edge with out_ready = 1; in_ready rises the following cycle (no same-cycle accept from DONE).
REQ-013 out_ready while out_valid = 0 SHALL be ignored; in_valid while in_ready = 0 SHALL be ignored without corrupting latched operands.

Reset
REQ-014 rst_n = 0 SHALL immediately, regardless of clk, force state IDLE, out_valid 0, out_sign 0, out_mag 0, out_twos 0, out_negzero 0, out_gt 0, busy 0; in_ready SHALL be 1 once rst_n = 1.
REQ-015 Reset asserted during CMP or DONE SHALL discard the operation; no out_valid for it SHALL ever appear.

Configuration
REQ-016 With AGC_DEC_EARLY_EXIT_EN defined, CMP SHALL end on the cycle the first differing magnitude bit is found (out_valid rises k edges after accept, k = 14 - bit index, 1..14), or after 14 cycles if equal; without it, latency SHALL be fixed per REQ-008. Results SHALL be identical in both builds.

Verification
REQ-017 in_word 15'h0005, in_ref 15'h0003 -> out_sign 0, out_mag 5, out_twos 15'h0005, out_gt 1, out_valid 14 edges after accept (macro off).
REQ-018 in_word 15'h7FFA (-5), in_ref 15'h7FFC (-3) -> out_sign 1, out_mag 5, out_twos 15'h7FFB, out_gt 0.
REQ-019 in_word 15'h7FFF, in_ref 15'h0000 -> out_negzero 1, out_sign 0, out_mag 0, out_twos 0, out_gt 0.
REQ-020 out_ready held 0 for 10 cycles in DONE -> outputs and out_valid stable, in_ready 0; out_ready 1 -> IDLE, in_ready 1 next cycle.
REQ-021 rst_n pulsed low at CMP cycle 7 -> all outputs reset values immediately; next operation completes with correct result.
REQ-022 Macro on: in_word 15'h2000, in_ref 15'h0000 -> out_valid 1 edge after accept, out_gt 1; macro off -> 14 edges, same result.

Source files
------------

// File: rtl/agc_word_decoder.sv
// ---------------------------------------------------------------------------
// agc_word_decoder
//
// Decodes one 15-bit AGC one's-complement word (bit 14 = sign, bits 13:0 =
// data) into sign, magnitude and two's-complement form. It also compares the
// word against a reference word. The magnitude compare is bit-serial: it
// scans from bit 13 down to bit 0, one bit per clock. An operand pair is
// accepted only in IDLE. The result is held in DONE until the consumer takes
// it.
//
// Configuration macro:
//   AGC_DEC_EARLY_EXIT_EN - when defined, the compare stops on the first
//                           differing magnitude bit instead of always
//                           scanning all 14 bits. Results are identical;
//                           only the latency changes.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   in_valid      operand pair offered
//   in_ready      high only in IDLE
//   in_word       word to decode (15 bits)
//   in_ref        reference word for the compare (15 bits)
//   out_valid     result available (DONE)
//   out_ready     consumer accepts the result
//   out_sign      effective sign (0 for either zero)
//   out_mag       14-bit magnitude
//   out_twos      15-bit two's-complement equivalent of in_word
//   out_negzero   in_word was negative zero (15'h7FFF)
//   out_gt        in_word > in_ref, signed one's-complement
//   busy          high only while the compare runs (CMP)
// ---------------------------------------------------------------------------
module agc_word_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] in_word,
    input  logic [14:0] in_ref,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [13:0] out_mag,
    output logic [14:0] out_twos,
    output logic        out_negzero,
    output logic        out_gt,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t      state, state_nxt;
    logic [14:0] word_q, ref_q;
    logic [3:0]  bit_idx;
    logic        mag_gt, mag_lt;

    logic [13:0] mag_w, mag_r;
    logic        sign_w, sign_r;
    logic        bit_w, bit_r;
    logic        bit_diff, last_bit, cmp_end, accept, done;
    logic        gt_comb;

    // A negative word stores its magnitude inverted. Negative zero therefore
    // decodes to magnitude 0, and its effective sign is forced to 0 below.
    assign mag_w  = word_q[14] ? ~word_q[13:0] : word_q[13:0];
    assign mag_r  = ref_q[14]  ? ~ref_q[13:0]  : ref_q[13:0];
    assign sign_w = word_q[14] && (mag_w != 14'd0);
    assign sign_r = ref_q[14]  && (mag_r != 14'd0);

    assign bit_w    = mag_w[bit_idx];
    assign bit_r    = mag_r[bit_idx];
    // The first differing bit decides the compare; later bits are ignored.
    assign bit_diff = (bit_w != bit_r) && !mag_gt && !mag_lt;
    assign last_bit = (bit_idx == 4'd0);

`ifdef AGC_DEC_EARLY_EXIT_EN
    assign cmp_end = last_bit || bit_diff;
`else
    assign cmp_end = last_bit;
`endif

    assign accept = in_valid && (state == IDLE);
    assign done   = (state == DONE);

    // Handshake and status come straight from the state. Reset moves the
    // state to IDLE at once, so every output drops to its reset value
    // without waiting for a clock edge.
    assign in_ready  = (state == IDLE);
    assign busy      = (state == CMP);
    assign out_valid = done;

    // Next-state logic.
    always_comb begin
        // NOTE: assign a default first so that no path through the block leaves state_nxt unassigned, which would infer a latch.
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = CMP;
            CMP:     if (cmp_end)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus the operand and compare datapath.
    // NOTE: every register, including the operand latches, has the asynchronous reset, so no stale operand can be seen after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            word_q  <= 15'd0;
            ref_q   <= 15'd0;
            bit_idx <= 4'd0;
            mag_gt  <= 1'b0;
            mag_lt  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this block based on the values from before the edge.
            state <= state_nxt;
            if (accept) begin
                word_q  <= in_word;
                ref_q   <= in_ref;
                bit_idx <= 4'd13;
                mag_gt  <= 1'b0;
                mag_lt  <= 1'b0;
            end else if (state == CMP) begin
                if (bit_diff) begin
                    mag_gt <= bit_w;
                    mag_lt <= bit_r;
                end
                if (!last_bit) bit_idx <= bit_idx - 4'd1;
            end
        end
    end

    // Signed compare. Zeros of either sign are equal. A sign difference
    // decides the result directly. Between two negatives, the larger
    // magnitude is the smaller value.
    always_comb begin
        gt_comb = 1'b0;
        if ((mag_w == 14'd0) && (mag_r == 14'd0))
            gt_comb = 1'b0;
        else if (sign_w != sign_r)
            gt_comb = !sign_w;
        else if (!sign_w)
            gt_comb = mag_gt;
        else
            gt_comb = mag_lt;
    end

    // Result outputs are valid only in DONE and are held at zero elsewhere.
    assign out_sign    = done && sign_w;
    assign out_mag     = done ? mag_w : 14'd0;
    assign out_twos    = !done ? 15'd0 :
                         sign_w ? (~{1'b0, mag_w} + 15'd1) : {1'b0, mag_w};
    assign out_negzero = done && (word_q == 15'h7FFF);
    assign out_gt      = done && gt_comb;

endmodule
